// File: rtl/oc8051_int_req.sv
// Interrupt-request front end for the 8051 test top: three active-low buttons are
// synchronised, debounced, edge-detected, latched as pending and issued by fixed priority.
module oc8051_int_req #(
    parameter int          DEB_BITS = 16,
    parameter logic [7:0]  VEC0     = 8'h40,
    parameter logic [7:0]  VEC1     = 8'h50,
    parameter logic [7:0]  VEC2     = 8'h65
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_n,
    input  logic       reti,
    output logic       int_req,   // one-cycle interrupt request pulse to the core
    output logic [7:0] int_v,
    output logic       int_act,
    output logic [2:0] pend,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACT  = 2'd2
    } state_t;

    localparam logic [DEB_BITS-1:0] DEB_MAX = '1;

    state_t              state, state_nxt;
    logic [2:0]          sync1, sync2, stable, press, grant;
    logic [7:0]          grant_vec;
    logic [DEB_BITS-1:0] cnt [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // A new level is accepted only after DEB_MAX consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 3'b111;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press = 3'b000;
        for (int i = 0; i < 3; i++)
            press[i] = (sync2[i] != stable[i]) && (cnt[i] == DEB_MAX) && !sync2[i];
    end

    // Fixed priority: lowest index wins; grants only happen in IDLE.
    always_comb begin
        grant     = 3'b000;
        grant_vec = VEC0;
        if (state == IDLE) begin
            if (pend[0]) begin
                grant     = 3'b001;
                grant_vec = VEC0;
            end else if (pend[1]) begin
                grant     = 3'b010;
                grant_vec = VEC1;
            end else if (pend[2]) begin
                grant     = 3'b100;
                grant_vec = VEC2;
            end
        end
    end

    // A press in the same cycle as its own grant keeps the request pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 3'b000;
            int_v <= 8'h00;
        end else begin
            pend <= (pend & ~grant) | press;
            if (grant != 3'b000) int_v <= grant_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend != 3'b000) state_nxt = REQ;
            REQ:     state_nxt = ACT;
            ACT:     if (reti) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        int_req   = (state == REQ);
        int_act   = (state == ACT);
        dbg_state = state;
    end

endmodule

// File: tb/tb_oc8051_int_req.sv
// Directed bench for oc8051_int_req with a short debounce (DEB_BITS=2, DEB_MAX=3).
module tb_oc8051_int_req;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_n = 3'b111;
    logic       reti = 1'b0;
    logic       int_req;
    logic [7:0] int_v;
    logic       int_act;
    logic [2:0] pend;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int seen;

    oc8051_int_req #(.DEB_BITS(2)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .reti(reti),
        .int_req(int_req), .int_v(int_v), .int_act(int_act),
        .pend(pend), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        step(1);
        reti = 1'b0;
    endtask

    // Watch n cycles and count int pulses and non-zero pend.
    task automatic watch(input int n, output int ints, output int pends);
        ints = 0;
        pends = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (int_req === 1'b1) ints++;
            if (pend !== 3'b000) pends++;
        end
    endtask

    initial begin
        int ni, np;
        // 1. reset with random inputs
        #1;
        for (int i = 0; i < 3; i++) begin
            btn_n = 3'($urandom_range(0, 7));
            reti  = 1'($urandom_range(0, 1));
            step(1);
            chk("rst_int", int_req, 1'b0);
            chk("rst_act", int_act, 1'b0);
            chk("rst_pend", pend, 3'b000);
            chk("rst_intv", int_v, 8'h00);
        end
        btn_n = 3'b111;
        reti  = 1'b0;
        step(1);
        rst = 1'b0;
        step(4);
        chk("post_rst_int", int_req, 1'b0);
        chk("post_rst_pend", pend, 3'b000);
        chk("post_rst_act", int_act, 1'b0);
        chk("post_rst_intv", int_v, 8'h00);

        // 2. single press on button 0; edge k is the next rising edge
        btn_n = 3'b110;
        step(5);
        chk("t2_pend_k4", pend, 3'b000);
        step(1);
        chk("t2_pend_k5", pend, 3'b001);
        chk("t2_int_k5", int_req, 1'b0);
        step(1);
        chk("t2_int_k6", int_req, 1'b1);
        chk("t2_intv_k6", int_v, 8'h40);
        chk("t2_pend_k6", pend, 3'b000);
        step(1);
        chk("t2_int_k7", int_req, 1'b0);
        chk("t2_act_k7", int_act, 1'b1);
        btn_n = 3'b111;
        watch(8, ni, np);
        chk("t2_release_ints", ni, 0);
        chk("t2_release_pend", np, 0);
        chk("t2_act_held", int_act, 1'b1);
        pulse_reti();
        chk("t2_act_reti", int_act, 1'b0);
        chk("t2_pend_reti", pend, 3'b000);
        chk("t2_intv_hold", int_v, 8'h40);
        watch(5, ni, np);
        chk("t2_idle_ints", ni, 0);

        // 3. two-cycle glitch on button 1 is rejected
        btn_n = 3'b101;
        step(2);
        btn_n = 3'b111;
        watch(10, ni, np);
        chk("t3_ints", ni, 0);
        chk("t3_pend", np, 0);

        // 4. buttons 0 and 2 together: 0 wins, 2 follows after reti
        btn_n = 3'b010;
        step(6);
        chk("t4_pend_k5", pend, 3'b101);
        chk("t4_int_k5", int_req, 1'b0);
        step(1);
        chk("t4_int_k6", int_req, 1'b1);
        chk("t4_intv_k6", int_v, 8'h40);
        chk("t4_pend_k6", pend, 3'b100);
        btn_n = 3'b111;
        step(1);
        chk("t4_act", int_act, 1'b1);
        step(8);
        pulse_reti();
        chk("t4_act_reti", int_act, 1'b0);
        chk("t4_int_reti", int_req, 1'b0);
        step(1);
        chk("t4_int2", int_req, 1'b1);
        chk("t4_intv2", int_v, 8'h65);
        chk("t4_pend2", pend, 3'b000);
        step(1);
        chk("t4_act2", int_act, 1'b1);

        // 5. two presses of button 1 while in service coalesce
        for (int p = 0; p < 2; p++) begin
            btn_n = 3'b101;
            step(8);
            btn_n = 3'b111;
            step(8);
        end
        chk("t5_pend", pend, 3'b010);
        chk("t5_act", int_act, 1'b1);
        pulse_reti();
        chk("t5_act_reti", int_act, 1'b0);
        watch(10, ni, np);
        chk("t5_one_int", ni, 1);
        chk("t5_intv", int_v, 8'h50);
        chk("t5_act_again", int_act, 1'b1);
        chk("t5_pend_clear", pend, 3'b000);
        pulse_reti();

        // 6. async reset in ACT with button 0 pending
        step(3);
        btn_n = 3'b110;
        step(8);
        btn_n = 3'b111;
        step(8);
        chk("t6_act_first", int_act, 1'b1);
        btn_n = 3'b110;
        step(8);
        btn_n = 3'b111;
        step(8);
        chk("t6_act", int_act, 1'b1);
        chk("t6_pend", pend, 3'b001);
        rst = 1'b1;
        #1;
        chk("t6_async_act", int_act, 1'b0);
        chk("t6_async_pend", pend, 3'b000);
        chk("t6_async_int", int_req, 1'b0);
        step(2);
        rst = 1'b0;
        watch(12, ni, np);
        chk("t6_no_int", ni, 0);
        chk("t6_no_pend", np, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
